// File: rtl/burst_slot_arbiter.sv
// burst_slot_arbiter: round-robin arbiter granting whole bursts of beats
// to NUM_REQ requesters in front of one shared, beat-oriented resource.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   req          per-requester request level
//   req_len      packed burst lengths, requester i at [i*LEN_W +: LEN_W]
//   res_ready    resource accepts the current beat
//   flush        abort the burst in progress (no burst_done)
//   grant        one-hot grant (registered)
//   grant_valid  burst in progress (registered)
//   grant_id     index of the granted requester (registered)
//   beat_idx     0-based beat within the burst (registered)
//   last_beat    current beat is the final one of the burst
//   burst_done   one-cycle pulse after a burst completes normally
module burst_slot_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 6,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic                     res_ready,
    input  logic                     flush,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     grant_valid,
    output logic [ID_W-1:0]          grant_id,
    output logic [LEN_W-1:0]         beat_idx,
    output logic                     last_beat,
    output logic                     burst_done
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [LEN_W-1:0]  len_q;

    logic [LEN_W-1:0]  lens [NUM_REQ];
    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   win_id;
    logic              win_found;
    logic [LEN_W-1:0]  win_len;
    logic [ID_W-1:0]   next_ptr;
    logic              burst_end;

    // A zero length still occupies one beat; oversize requests are cut
    // to the longest burst the resource is sized for.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l == '0)
            return LEN_W'(1);
        else if (int'(l) > MAX_BURST)
            return LEN_W'(MAX_BURST);
        else
            return l;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            lens[i] = req_len[i*LEN_W +: LEN_W];
    end

    // Rotating priority: first requester at or above ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign win_len  = clamp_len(lens[win_id]);
    assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0
                                                       : grant_id + 1'b1;

    assign last_beat = grant_valid && (beat_idx == len_q - 1'b1);

    // Flush wins over a simultaneous last-beat acceptance.
    assign burst_end = flush || (res_ready && last_beat);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            len_q       <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            beat_idx    <= '0;
            burst_done  <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state       <= BURST;
                        grant       <= NUM_REQ'(1) << win_id;
                        grant_valid <= 1'b1;
                        grant_id    <= win_id;
                        len_q       <= win_len;
                        beat_idx    <= '0;
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        state       <= IDLE;
                        ptr         <= next_ptr;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_id    <= '0;
                        beat_idx    <= '0;
                        burst_done  <= !flush;
                    end else if (res_ready) begin
                        beat_idx <= beat_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/burst_slot_arbiter.md
# burst_slot_arbiter

Round-robin arbiter that shares one beat-oriented resource, such as a pipelined compute lane or a counter-sequenced datapath, among `NUM_REQ` requesters. It grants one requester at a time for a whole burst of 1..`MAX_BURST` beats. It tracks beat progress with an internal beat counter that wraps per burst, honours downstream backpressure, and rotates priority after every burst. It sits between the requester front-ends and the shared resource's issue port.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; must be ≥ 2.
- `MAX_BURST`, 6: maximum beats per burst; must be ≥ 1.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester index.
- `LEN_W`, `$clog2(MAX_BURST+1)`: width of burst length and beat index.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  `NUM_REQ`  per-requester request level.
- `req_len`  in  `NUM_REQ*LEN_W`  requested burst length; requester i occupies bits [i*LEN_W +: LEN_W].
- `res_ready`  in  1  resource accepts the current beat.
- `flush`  in  1  abort the current burst.
- `grant`  out  `NUM_REQ`  one-hot grant, registered.
- `grant_valid`  out  1  a burst is in progress, registered.
- `grant_id`  out  `ID_W`  index of the granted requester, registered.
- `beat_idx`  out  `LEN_W`  index of the current beat within the burst, 0-based, registered.
- `last_beat`  out  1  `grant_valid` && `beat_idx` == `len_q`-1; combinational from registers.
- `burst_done`  out  1  one-cycle pulse after a burst ends normally, registered.

## Operation
- The FSM has two states: IDLE and BURST.
- **IDLE:**
  - If any `req` bit is set, select the first set bit scanning upward from `ptr` and wrapping modulo `NUM_REQ`.
  - On the next edge, latch `grant_id`, the one-hot `grant`, and `len_q` (the clamped `req_len` of the winner). Set `beat_idx`=0 and `grant_valid`=1, and go to BURST.
  - If no `req` bit is set, stay in IDLE with all grant outputs at 0.
- **Length clamping:**
  - A `req_len` of 0 is treated as 1.
  - A `req_len` greater than `MAX_BURST` is treated as `MAX_BURST`.
  - `req_len` is sampled only in the arbitration cycle; later changes are ignored.
- **BURST:**
  - A beat is accepted when `res_ready`=1.
  - On an accepted beat that is not the last, `beat_idx` increments by 1.
  - On an accepted last beat, go to IDLE and clear `grant`, `grant_valid` and `beat_idx`. Set `ptr` to (`grant_id`+1) mod `NUM_REQ` and assert `burst_done` for one cycle.
  - When `res_ready`=0, all state holds.
- **Commitment:** dropping `req` mid-burst does not end the burst. The burst runs to `len_q` beats unless flushed.
- **Flush:**
  - `flush`=1 in BURST returns the FSM to IDLE on the next edge and clears the grant outputs.
  - `ptr` advances as for a normal end. `burst_done` is not asserted.
  - `flush` has priority over a simultaneous last-beat acceptance, so `burst_done` stays 0.
  - `flush` in IDLE is ignored, and arbitration proceeds normally.
- **Reset:**
  - All outputs go to 0, `ptr`=0, `len_q`=0, state IDLE.
  - Reset has priority over all other inputs, including mid-burst; the burst is discarded.
- **Arithmetic:** `beat_idx` never exceeds `len_q`-1. `ptr` wraps from `NUM_REQ`-1 to 0.

## Timing
- **Grant latency:** a `req` seen in IDLE at cycle t gives `grant_valid`=1 at t+1.
- **Burst length:** with `res_ready` held high, a burst of length L holds its grant for cycles t+1 .. t+L.
- **Turnaround:** IDLE occurs at t+L+1 with `burst_done`=1, and the next grant appears at t+L+2. There is exactly one arbitration cycle between bursts, so peak utilisation is L/(L+1).
- **Last beat:** `last_beat` is valid in the same cycle as the beat it marks. It stays high across stalls on the last beat.
- **Output stability:** `grant`, `grant_id` and `grant_valid` are constant throughout a burst, including while stalled.

## Test plan
- **Reset:** assert `reset` for 2 cycles with all `req`=1. Required: `grant`=0, `grant_valid`=0, `beat_idx`=0, `burst_done`=0; after release, the first grant goes to requester 0.
- **Single burst:** `req`=4'b0100, `len`=3, `res_ready`=1. Required: `grant`=4'b0100 for 3 cycles, `beat_idx` 0,1,2, `last_beat` on beat 2, then one IDLE cycle with `burst_done`=1.
- **Round-robin fairness:** `req`=4'b1111, all `len`=1, held for 12 cycles. Required: grant order 0,1,2,3,0,1; each grant lasts 1 cycle, separated by 1 IDLE cycle.
- **Backpressure:** `len`=2; `res_ready` pattern 1,0,0,1. Required: `beat_idx` 0,1,1,1, then IDLE; `grant` is stable throughout.
- **Flush:** `len`=5; assert `flush` at `beat_idx`=2. Required: next cycle IDLE, `burst_done`=0, next grant goes to the next requester in rotation.
- **Clamping and mid-burst reset:**
  - `len`=0 gives a 1-beat burst.
  - `len`=7 with `MAX_BURST`=6 gives a 6-beat burst.
  - `reset` at beat 3 gives all outputs 0 on the next cycle, and `ptr` restarts at 0.
